// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// one-cycle strobes for a good byte (rx_valid) or a low stop bit (frame_err).
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned FREQ_CLKIN = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = FREQ_CLKIN / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_WIDTH    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_WIDTH-1:0] CNT_HALF_END = CNT_WIDTH'(HALF_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_BIT_END  = CNT_WIDTH'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rx_sync;

  assign rx_sync = sync_q[1];

  // Register bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rxd};
    cnt_d       = cnt_q + CNT_WIDTH'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF_END) state_d = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          if (rx_sync) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter and bit index restart on every state change
    if (state_d != state_q) begin
      cnt_d     = '0;
      bit_idx_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
